demux5_buffered: RTL and testbench
==================================

Name: demux5_buffered

Overview:
- Inverse of the 5-way source select: one 32-bit producer stream, routed by a 3-bit select to one of five destinations.
- Each destination has a one-entry registered slot and a valid/ready handshake. A stalled destination blocks only traffic addressed to it.
- Sits between a shared result bus and five consumers (register-file write port, memory write data, PC update, HI, LO).
- Select codes 5..7 are illegal: data is consumed, discarded and counted.

Parameters:
- WIDTH, 32, data width of input and every destination.
- SEL_W, 3, select width; codes 0..4 map to destinations 1..5.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_data/in_select this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- in_select  input  SEL_W  destination code for the offered word.
- in_data  input  WIDTH  payload.
- out_valid  output  5  bit i: destination i+1 slot holds a word.
- out_ready  input  5  bit i: destination i+1 consumes this cycle.
- dst1..dst5  output  WIDTH each  slot contents for destinations 1..5.
- drop_pulse  output  1  one-cycle pulse: an illegal-select word was accepted last cycle.
- drop_count  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (async, rst_n=0):
  - All slots empty, so out_valid=0.
  - dst1..dst5=0, drop_pulse=0, drop_count=0.
  - in_ready follows its combinational rule using empty slots, so it is 1.
  - Reset mid-transfer discards any slot contents; no word is emitted after release.
- in_ready, combinational:
  - in_select<=4: in_ready = ~full[sel] | out_ready[sel].
  - in_select>=5: in_ready = 1.
  - Depends only on in_select, slot state and out_ready, never on in_valid.
- Accept: in_valid & in_ready on a rising edge.
  - Latency: a word accepted at edge N is visible on dst[sel] with out_valid[sel]=1 from edge N onward, i.e. one cycle after presentation.
  - No combinational in_data-to-dst path.
- Slot i update per edge, in priority order:
  1. Accept to i → data loaded, full=1. This also covers a simultaneous drain, giving full throughput of 1 word/cycle per destination.
  2. Else drain (out_valid[i] & out_ready[i]) → full=0.
  3. Else hold.
- Data stability:
  - dst_i is held stable while out_valid[i]=1 and out_ready[i]=0.
  - After a drain, dst_i keeps its last value; it is not cleared.
- Independence:
  - Accepts to different destinations in consecutive cycles proceed regardless of other slots' state.
  - Only one accept per cycle (single input).
- Illegal select accept:
  - drop_pulse=1 for the following cycle.
  - drop_count increments, saturating at 2^CNT_W-1 and holding there.
  - No slot changes.
- out_ready to an empty slot is ignored.
- in_valid may drop without transfer; no stickiness is required of the producer.

Decomposition:
- Shared package demux_pkg holds:
  - DST_COUNT=5, SEL_ILLEGAL_MIN=3'd5.
  - The select-code constants SEL_DST1..SEL_DST5.
- Natural sub-module: demux_slot, a one-entry buffer.
  - Inputs: load, load_data, drain.
  - Outputs: full, data.
  - Instantiated five times.
- Counter and in_ready logic live in the top module.

Test Plan:
- Reset then in_valid=1, sel=2, data=0xDEADBEEF → in_ready=1. After the edge: out_valid=5'b00100, dst3=0xDEADBEEF, other dst=0.
- dst3 full with out_ready[2]=0; offer sel=2, data=0x1 → in_ready=0. Offer sel=0 the same cycle instead → in_ready=1 and dst1=0x1 next cycle.
- dst3 full with out_ready[2]=1; offer sel=2, data=0x22 → accepted. out_valid[2] stays 1 and dst3=0x22 next cycle (back-to-back, no bubble).
- Offer sel=7, data=0xAA for 300 consecutive cycles → in_ready=1 and drop_pulse high each following cycle. drop_count reaches 255 and holds; out_valid stays 0.
- Fill slots 1 and 4, then assert rst_n=0 asynchronously mid-cycle → out_valid=0 and dst1..dst5=0 immediately. After release, no output is emitted until a new accept.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the five-way buffered result demultiplexer.
// Destination codes 0..4 select consumers 1..5; codes 5..7 are dropped.
package demux_pkg;

  localparam int DST_COUNT = 5;

  localparam logic [2:0] SEL_ILLEGAL_MIN = 3'd5;

  typedef enum logic [2:0] {
    SEL_DST1 = 3'd0,
    SEL_DST2 = 3'd1,
    SEL_DST3 = 3'd2,
    SEL_DST4 = 3'd3,
    SEL_DST5 = 3'd4
  } dst_sel_e;

  // True when a select code addresses a real destination slot.
  function automatic logic sel_is_legal(input logic [2:0] sel);
    return sel < SEL_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered buffer feeding a single destination.
// A load wins over a drain so a full slot can be refilled in the same
// cycle it empties, sustaining one word per cycle.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: load first, otherwise drain clears only the flag so the
  // last word stays visible on the data output.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // State registers; reset empties the slot and clears the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/demux5_buffered.sv
// Routes one producer stream to five buffered consumers by select code.
// Illegal select codes are always accepted, discarded and counted.
module demux5_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_select,
  input  logic [WIDTH-1:0]     in_data,
  output logic [DST_COUNT-1:0] out_valid,
  input  logic [DST_COUNT-1:0] out_ready,
  output logic [WIDTH-1:0]     dst1,
  output logic [WIDTH-1:0]     dst2,
  output logic [WIDTH-1:0]     dst3,
  output logic [WIDTH-1:0]     dst4,
  output logic [WIDTH-1:0]     dst5,
  output logic                 drop_pulse,
  output logic [CNT_W-1:0]     drop_count
);

  logic [DST_COUNT-1:0] slotFull;
  logic [DST_COUNT-1:0] slotLoad;
  logic [DST_COUNT-1:0] slotDrain;
  logic [WIDTH-1:0]     slotData [DST_COUNT];
  logic                 selIllegal;
  logic                 accept;

  logic             drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  assign selIllegal = !sel_is_legal(3'(in_select));
  assign accept     = in_valid & in_ready;

  // Readiness depends only on the addressed slot and its consumer, never on
  // in_valid, so the producer can look at it before committing.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < DST_COUNT; i++) begin
      if (in_select == SEL_W'(i)) begin
        in_ready = ~slotFull[i] | out_ready[i];
      end
    end
  end

  // Per-slot load and drain strobes; a drain on an empty slot is ignored.
  always_comb begin
    slotLoad  = '0;
    slotDrain = '0;
    for (int i = 0; i < DST_COUNT; i++) begin
      slotLoad[i]  = accept & (in_select == SEL_W'(i));
      slotDrain[i] = slotFull[i] & out_ready[i];
    end
  end

  genvar g;
  generate
    for (g = 0; g < DST_COUNT; g++) begin : gSlot
      demux_slot #(.WIDTH(WIDTH)) uSlot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (slotLoad[g]),
        .load_data (in_data),
        .drain     (slotDrain[g]),
        .full      (slotFull[g]),
        .data      (slotData[g])
      );
    end
  endgenerate

  // Drop bookkeeping: pulse follows every illegal accept, counter saturates.
  always_comb begin
    drop_pulse_d = accept & selIllegal;
    drop_count_d = drop_count_q;
    if (drop_pulse_d && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  // Drop registers; cleared by reset along with the slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = slotFull;
  assign dst1       = slotData[0];
  assign dst2       = slotData[1];
  assign dst3       = slotData[2];
  assign dst4       = slotData[3];
  assign dst5       = slotData[4];
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux5_buffered.sv
// Directed bench for the five-way buffered demultiplexer.
module tb_demux5_buffered;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_select;
  logic [31:0] in_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [31:0] dst1, dst2, dst3, dst4, dst5;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  int total;
  int bad;

  demux5_buffered #(.WIDTH(32), .SEL_W(3), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dst1       (dst1),
    .dst2       (dst2),
    .dst3       (dst3),
    .dst4       (dst4),
    .dst5       (dst5),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_select = 3'd2;
    in_data   = 32'h0;
    out_ready = 5'b00000;
    #13;
    total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=%b", out_valid, 5'b00000); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("[TB] FAIL reset_drop_pulse got=%b want=0", drop_pulse); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop_count got=%0d want=0", drop_count); end
    total++; if ({dst1, dst2, dst3, dst4, dst5} !== 160'h0) begin bad++; $display("[TB] FAIL reset_dst got=%h want=0", {dst1, dst2, dst3, dst4, dst5}); end
    rst_n = 1'b1;
    stepCycle();
  endtask

  task automatic test_route();
    in_valid  = 1'b1;
    in_select = 3'd2;
    in_data   = 32'hDEADBEEF;
    out_ready = 5'b00000;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL route_in_ready got=%b want=1", in_ready); end
    stepCycle();
    total++; if (out_valid !== 5'b00100) begin bad++; $display("[TB] FAIL route_out_valid got=%b want=%b", out_valid, 5'b00100); end
    total++; if (dst3 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL route_dst3 got=%h want=deadbeef", dst3); end
    total++; if ({dst1, dst2, dst4, dst5} !== 128'h0) begin bad++; $display("[TB] FAIL route_other_dst got=%h want=0", {dst1, dst2, dst4, dst5}); end
  endtask

  task automatic test_stall();
    in_valid  = 1'b1;
    in_select = 3'd2;
    in_data   = 32'h1;
    out_ready = 5'b00000;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready got=%b want=0", in_ready); end
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready_no_valid got=%b want=0", in_ready); end
    in_valid  = 1'b1;
    in_select = 3'd0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_other_ready got=%b want=1", in_ready); end
    stepCycle();
    total++; if (dst1 !== 32'h1) begin bad++; $display("[TB] FAIL stall_dst1 got=%h want=1", dst1); end
    total++; if (out_valid !== 5'b00101) begin bad++; $display("[TB] FAIL stall_out_valid got=%b want=%b", out_valid, 5'b00101); end
    total++; if (dst3 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL stall_dst3_hold got=%h want=deadbeef", dst3); end
  endtask

  task automatic test_back_to_back();
    in_valid  = 1'b1;
    in_select = 3'd2;
    in_data   = 32'h22;
    out_ready = 5'b00100;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready got=%b want=1", in_ready); end
    stepCycle();
    total++; if (out_valid !== 5'b00101) begin bad++; $display("[TB] FAIL b2b_out_valid got=%b want=%b", out_valid, 5'b00101); end
    total++; if (dst3 !== 32'h22) begin bad++; $display("[TB] FAIL b2b_dst3 got=%h want=22", dst3); end
    in_data = 32'h33;
    stepCycle();
    total++; if (dst3 !== 32'h33) begin bad++; $display("[TB] FAIL b2b_dst3_second got=%h want=33", dst3); end
    total++; if (out_valid !== 5'b00101) begin bad++; $display("[TB] FAIL b2b_out_valid_second got=%b want=%b", out_valid, 5'b00101); end
    in_valid  = 1'b0;
    out_ready = 5'b00101;
    stepCycle();
    total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL drain_out_valid got=%b want=0", out_valid); end
    total++; if (dst3 !== 32'h33 || dst1 !== 32'h1) begin bad++; $display("[TB] FAIL drain_keep got=%h/%h want=33/1", dst3, dst1); end
    out_ready = 5'b11111;
    stepCycle();
    total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL empty_ready_ignored got=%b want=0", out_valid); end
    out_ready = 5'b00000;
  endtask

  task automatic test_illegal();
    int expCount;
    expCount  = 0;
    in_valid  = 1'b0;
    in_select = 3'd5;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL illegal_ready_idle got=%b want=1", in_ready); end
    stepCycle();
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("[TB] FAIL illegal_no_valid_pulse got=%b want=0", drop_pulse); end
    in_valid  = 1'b1;
    in_select = 3'd7;
    in_data   = 32'hAA;
    for (int i = 0; i < 300; i++) begin
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL illegal_ready cyc=%0d got=%b want=1", i, in_ready); end
      stepCycle();
      if (expCount < 255) expCount++;
      total++; if (drop_pulse !== 1'b1) begin bad++; $display("[TB] FAIL illegal_pulse cyc=%0d got=%b want=1", i, drop_pulse); end
      total++; if (drop_count !== 8'(expCount)) begin bad++; $display("[TB] FAIL illegal_count cyc=%0d got=%0d want=%0d", i, drop_count, expCount); end
      total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL illegal_out_valid cyc=%0d got=%b want=0", i, out_valid); end
    end
    in_valid = 1'b0;
    stepCycle();
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("[TB] FAIL illegal_pulse_end got=%b want=0", drop_pulse); end
    total++; if (drop_count !== 8'd255) begin bad++; $display("[TB] FAIL illegal_count_hold got=%0d want=255", drop_count); end
    total++; if (dst3 !== 32'h33) begin bad++; $display("[TB] FAIL illegal_dst_unchanged got=%h want=33", dst3); end
  endtask

  task automatic test_async_reset();
    in_valid  = 1'b1;
    in_select = 3'd0;
    in_data   = 32'h11;
    out_ready = 5'b00000;
    stepCycle();
    in_select = 3'd3;
    in_data   = 32'h44;
    stepCycle();
    in_valid = 1'b0;
    total++; if (out_valid !== 5'b01001) begin bad++; $display("[TB] FAIL arst_prefill got=%b want=%b", out_valid, 5'b01001); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL arst_out_valid got=%b want=0", out_valid); end
    total++; if ({dst1, dst2, dst3, dst4, dst5} !== 160'h0) begin bad++; $display("[TB] FAIL arst_dst got=%h want=0", {dst1, dst2, dst3, dst4, dst5}); end
    total++; if (drop_count !== 8'd0) begin bad++; $display("[TB] FAIL arst_drop_count got=%0d want=0", drop_count); end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      total++; if (out_valid !== 5'b00000) begin bad++; $display("[TB] FAIL arst_quiet cyc=%0d got=%b want=0", i, out_valid); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_route();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
